// File: rtl/gcd_pkg.sv
// Shared defaults and state encoding for the GCD host sequencer.
package gcd_pkg;

    localparam int GCD_WIDTH          = 16;
    localparam int GCD_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT,
        RESP
    } gcd_state_t;

endpackage

// File: rtl/gcd_wait_timer.sv
// WAIT-phase timer: saturating cycle count, first-cycle blanking flag and a
// down-counter whose terminal count marks the watchdog expiry.
module gcd_wait_timer
    import gcd_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             blank,
    output logic             expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TW-1:0] remain;

    // clear arms the timer for the first WAIT cycle: count=1, blank set,
    // remain=TIMEOUT-1 so terminal count lands on WAIT cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            blank  <= 1'b0;
            remain <= '0;
        end else if (clear) begin
            count  <= CNT_W'(1);
            blank  <= 1'b1;
            remain <= TW'(TIMEOUT_CYCLES - 1);
        end else if (enable) begin
            if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end
            if (remain != '0) begin
                remain <= remain - TW'(1);
            end
            blank <= 1'b0;
        end
    end

    assign expired = (remain == '0);

endmodule

// File: rtl/gcd_host_sequencer.sv
// Initiator-side sequencer for the GCD core: request capture, operand
// serialization, watchdog-bounded wait and response hand-back.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for an operand pair
// SEND_A | core_start pulse, operand A on core_data
// SEND_B | operand B on core_data
// WAIT   | B held on core_data, waiting for core_done or watchdog
// RESP   | response valid, payload held until rsp_ready
module gcd_host_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH,
    parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rsp_cycles
);

    gcd_state_t       state;
    logic [WIDTH-1:0] op_b;
    logic             tmr_clear;
    logic             tmr_enable;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_blank;
    logic             tmr_expired;
    logic             done_seen;

    assign tmr_clear  = (state == SEND_B);
    assign tmr_enable = (state == WAIT);
    // A done still high from the previous operation is masked for one cycle.
    assign done_seen  = core_done && !tmr_blank;

    gcd_wait_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .count   (tmr_count),
        .blank   (tmr_blank),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_b       <= '0;
            req_ready  <= 1'b1;
            core_start <= 1'b0;
            core_data  <= '0;
            rsp_valid  <= 1'b0;
            rsp_gcd    <= '0;
            rsp_err    <= 1'b0;
            rsp_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_b      <= req_b;
                        req_ready <= 1'b0;
                        // The subtractive core never terminates on a zero operand.
                        if (req_a == '0 || req_b == '0) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_gcd    <= req_a | req_b;
                            rsp_err    <= 1'b0;
                            rsp_cycles <= '0;
                        end else begin
                            state      <= SEND_A;
                            core_start <= 1'b1;
                            core_data  <= req_a;
                        end
                    end
                end
                SEND_A: begin
                    state      <= SEND_B;
                    core_start <= 1'b0;
                    core_data  <= op_b;
                end
                SEND_B: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_seen) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_gcd    <= core_result;
                        rsp_err    <= 1'b0;
                        rsp_cycles <= tmr_count;
                    end else if (tmr_expired) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_gcd    <= '0;
                        rsp_err    <= 1'b1;
                        rsp_cycles <= CNT_W'(TIMEOUT_CYCLES);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    core_start <= 1'b0;
                    rsp_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Self-checking bench for gcd_host_sequencer: directed scenarios plus
// randomized requests against an arithmetic reference and a GCD core model.
module tb_gcd_host_sequencer;

    localparam int W  = 16;
    localparam int T  = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          core_start;
    logic [W-1:0]  core_data;
    logic          core_done;
    logic [W-1:0]  core_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_gcd;
    logic          rsp_err;
    logic [CW-1:0] rsp_cycles;

    int total = 0;
    int bad   = 0;
    int core_lat   = 0;
    bit core_stale = 0;

    gcd_host_sequencer #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_gcd     (rsp_gcd),
        .rsp_err     (rsp_err),
        .rsp_cycles  (rsp_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // GCD core model: latches A on start, B the next cycle, raises done in WAIT
    // cycle core_lat (0 = never) and keeps it high; optional stale done early.
    initial begin
        int wcnt;
        int k;
        int m_lat;
        bit m_stale;
        logic [15:0] ca;
        logic [15:0] cb;
        wcnt = -1; m_lat = 0; m_stale = 0; ca = '0; cb = '0;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                wcnt = 0;
                ca = core_data;
                m_lat = core_lat;
                m_stale = core_stale;
            end else if (wcnt >= 0 && wcnt < 100000) begin
                wcnt++;
            end
            if (wcnt == 1) cb = core_data;
            if (wcnt >= 0) begin
                k = wcnt - 1;
                if (m_lat != 0 && k >= m_lat) begin
                    core_done = 1'b1;
                    core_result = ref_gcd(ca, cb);
                end else if (m_stale && k <= 1) begin
                    core_done = 1'b1;
                    core_result = 16'hBEEF;
                end else begin
                    core_done = 1'b0;
                    core_result = 16'($urandom);
                end
            end
        end
    end

    // Caller is at a negedge; returns at the negedge after the response handshake.
    task automatic txn(input logic [15:0] a, input logic [15:0] b, input int lat,
                       input bit stale, input int hold, input string tag);
        int n;
        int cyc;
        int starts;
        int exp_lat;
        int exp_starts;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] exp_g;
        logic        exp_e;
        int          exp_c;
        logic [15:0] g0;
        logic        e0;
        logic [15:0] c0;
        bit seen;
        bit stable;

        if (a == 16'd0 || b == 16'd0) begin
            exp_g = a | b; exp_e = 1'b0; exp_c = 0; exp_lat = 1; exp_starts = 0;
        end else if (lat != 0 && lat <= T) begin
            exp_g = ref_gcd(a, b); exp_e = 1'b0; exp_c = lat; exp_lat = 3 + lat; exp_starts = 1;
        end else begin
            exp_g = 16'd0; exp_e = 1'b1; exp_c = T; exp_lat = 3 + T; exp_starts = 1;
        end

        core_lat = lat;
        core_stale = stale;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(n < 100), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 16'($urandom);
        req_b = 16'($urandom);

        cyc = 1; starts = 0; seen = 0; d1 = '0; d2 = '0;
        while (cyc < 200) begin
            if (core_start === 1'b1) starts++;
            if (cyc == 1) d1 = core_data;
            if (cyc == 2) d2 = core_data;
            if (rsp_valid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_starts"}, 32'(starts), 32'(exp_starts));
        if (exp_starts == 1) begin
            chk({tag, "_data_a"}, 32'(d1), 32'(a));
            chk({tag, "_data_b"}, 32'(d2), 32'(b));
        end
        chk({tag, "_gcd"}, 32'(rsp_gcd), 32'(exp_g));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        chk({tag, "_cycles"}, 32'(rsp_cycles), 32'(exp_c));

        g0 = rsp_gcd; e0 = rsp_err; c0 = rsp_cycles;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_gcd !== g0 ||
                rsp_err !== e0 || rsp_cycles !== c0)
                stable = 0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(stable), 32'd1);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_core_start"}, 32'(core_start), 32'd0);
        chk({tag, "_core_data"}, 32'(core_data), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_gcd"}, 32'(rsp_gcd), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_cycles"}, 32'(rsp_cycles), 32'd0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int lat;
        bit seen;

        rst_n = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        txn(16'd143, 16'd78, 20, 0, 0, "nominal");
        txn(16'd0, 16'd48, 5, 0, 0, "zero_a");
        txn(16'd0, 16'd0, 5, 0, 0, "zero_both");
        txn(16'd48, 16'd0, 5, 0, 0, "zero_b");
        txn(16'd1000, 16'd250, 0, 0, 0, "timeout");
        txn(16'd9, 16'd6, 4, 0, 0, "after_timeout");
        txn(16'd60, 16'd42, T, 0, 0, "done_at_limit");
        txn(16'd60, 16'd42, T + 1, 0, 0, "done_past_limit");
        txn(16'd91, 16'd35, 5, 1, 10, "stale_bp");
        txn(16'd64, 16'd48, 2, 1, 0, "stale_lat2");

        // Reset in the middle of WAIT: no response may follow.
        core_lat = 10;
        core_stale = 0;
        req_a = 16'd200;
        req_b = 16'd150;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1;
        end
        chk("mid_reset_no_rsp", 32'(seen), 32'd0);
        txn(16'd36, 16'd24, 8, 0, 0, "post_reset");

        txn(16'd17, 16'd5, 3, 0, 0, "b2b_0");
        txn(16'd100, 16'd75, 6, 0, 0, "b2b_1");
        txn(16'd7, 16'd7, 2, 0, 0, "b2b_2");

        for (int i = 0; i < 40; i++) begin
            int f;
            f = $urandom_range(1, 50);
            a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'(f * $urandom_range(1, 1000));
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'(f * $urandom_range(1, 1000));
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(2, 40);
            txn(a, b, lat, bit'($urandom_range(0, 3) == 0), $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_host_sequencer.md
Name: gcd_host_sequencer

Overview:
Initiator-side driver for the GCD calculator core. It accepts an operand pair over a valid/ready request port and serializes the operands onto the core's shared operand bus with a start pulse. It then waits for the core's done, captures the result, and returns it on a valid/ready response port. Operand-zero cases, which the subtractive core cannot terminate on, are resolved locally, and a watchdog bounds every core transaction.

Parameters:
WIDTH, 16, operand/result width; must match the core datapath width
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before aborting with error
CNT_W, 16, width of the rsp_cycles counter; saturates, never wraps

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request operands valid
req_ready  output  1  sequencer can accept a request
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
core_start  output  1  start pulse to GCD core
core_data  output  WIDTH  serialized operand bus to core (A, then B)
core_done  input  1  core completion flag, level
core_result  input  WIDTH  core result, valid while core_done=1
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_gcd  output  WIDTH  GCD result (0 on error)
rsp_err  output  1  1 = watchdog timeout
rsp_cycles  output  CNT_W  cycles spent in WAIT (0 for local shortcut)

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state=IDLE, req_ready=1, core_start=0, core_data=0.
  - rsp_valid=0, rsp_gcd=0, rsp_err=0, rsp_cycles=0.
- Reset mid-operation abandons the transaction with no response; the core is not notified.
- States: IDLE, SEND_A, SEND_B, WAIT, RESP.
- req_ready=1 only in IDLE. A request is accepted on req_valid&&req_ready, and A/B are registered.
- IDLE, on accept, routes as follows:
  - If A==0 or B==0: go to RESP next cycle with rsp_gcd = A|B (0 if both zero), rsp_err=0, rsp_cycles=0. Latency is 1 cycle and no core traffic occurs.
  - Otherwise go to SEND_A.
- SEND_A (1 cycle): core_start=1, core_data=A.
- SEND_B (1 cycle): core_start=0, core_data=B.
- WAIT:
  - core_data holds B.
  - The cycle counter starts at 1 on the first WAIT cycle and increments each cycle, saturating at 2^CNT_W-1.
  - core_done is ignored in the first WAIT cycle (blanking for a stale done from the previous operation) and sampled from the second cycle on.
  - On core_done=1: capture core_result into rsp_gcd, rsp_err=0, rsp_cycles=counter, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without done: rsp_gcd=0, rsp_err=1, rsp_cycles=TIMEOUT_CYCLES, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1 and the payload is held stable until rsp_ready=1.
  - On handshake: rsp_valid drops next cycle and the state returns to IDLE, where req_ready=1. Minimum request-to-request spacing is therefore one IDLE cycle.
- core_start is only ever asserted for exactly one cycle per core transaction.
- Outputs are registered; no combinational path from req_* or core_* to any output.

Decomposition:
- Package gcd_pkg holds:
  - WIDTH default
  - the state enum {IDLE, SEND_A, SEND_B, WAIT, RESP}
  - the TIMEOUT_CYCLES default
- Sub-module gcd_wait_timer owns the saturating WAIT cycle counter, the blanking flag and the timeout compare. It has ports clk, rst_n, clear, enable, count, blank, expired.
- FSM and datapath registers stay in gcd_host_sequencer.

Test Plan:
1. Nominal: req A=143, B=78; the core model asserts done with result 13 after 20 WAIT cycles -> core_start one cycle with core_data=143, next cycle core_data=78; rsp_gcd=13, rsp_err=0, rsp_cycles=20.
2. Zero operands: A=0,B=48 -> rsp_gcd=48; then A=0,B=0 -> rsp_gcd=0. Both at latency 1 with core_start never asserted and rsp_cycles=0.
3. Timeout: TIMEOUT_CYCLES=32, core never asserts done -> rsp_valid with rsp_gcd=0, rsp_err=1, rsp_cycles=32. A following request is accepted normally.
4. Stale done / backpressure:
   - core_done held high from the previous op during the first WAIT cycle -> ignored.
   - rsp_ready held low for 10 cycles -> rsp_valid and payload stable, req_ready=0 throughout.
5. Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> all outputs return to reset values immediately and no response is emitted. The next request 36/24 -> rsp_gcd=12.
6. Back-to-back: requests (17,5), (100,75), (7,7) with rsp_ready=1 -> responses 1, 25, 7 in order, with one IDLE cycle between the handshakes.
